// File: rtl/axi_ram_slave.sv
// axi_ram_slave: reduced-AXI responder over a word-organised RAM with independent read/write FSMs.
// Optional feature macro AXI_RAM_RANDOM_STALL_EN adds LFSR-driven handshake bubbles.
module axi_ram_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_LEN    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic        bvalid,
    input  logic        bready
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {R_IDLE, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [31:0] mem [DEPTH];

    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] r_idx_q, r_idx_d, rd_addr;
    logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [31:0]           rdata_q;
    logic                  r_shown_q, r_shown_d, rd_en, ar_len_err;

    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] w_idx_q, w_idx_d;
    logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]            w_size_q, w_size_d;
    logic                  b_shown_q, b_shown_d, wr_en;
    logic                  proto_err_q, proto_err_d;
    logic [2:0]            strb_cnt;
    logic                  strb_err;

    logic stall_a, stall_r, stall_w, stall_b;

`ifdef AXI_RAM_RANDOM_STALL_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= 16'hACE1;
        else      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
    assign stall_a = lfsr_q[0];
    assign stall_r = lfsr_q[1];
    assign stall_w = lfsr_q[2];
    assign stall_b = lfsr_q[3];
`else
    assign stall_a = 1'b0;
    assign stall_r = 1'b0;
    assign stall_w = 1'b0;
    assign stall_b = 1'b0;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{araddr[31:ADDR_WIDTH+2], araddr[1:0], awaddr[31:ADDR_WIDTH+2], awaddr[1:0]};

    function automatic logic [7:0] clamp_len(input logic [7:0] len);
        return (int'(len) > MAX_LEN) ? 8'(MAX_LEN) : len;
    endfunction

    // Once a valid has been shown it stays up until accepted, even if a bubble is requested.
    always_comb begin
        r_state_d  = r_state_q;
        r_idx_d    = r_idx_q;
        r_len_d    = r_len_q;
        r_cnt_d    = r_cnt_q;
        r_shown_d  = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = r_idx_q;
        ar_len_err = 1'b0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        rlast      = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                arready = !stall_a;
                if (arvalid && !stall_a) begin
                    r_idx_d    = araddr[ADDR_WIDTH+1:2];
                    r_len_d    = clamp_len(arlen);
                    ar_len_err = int'(arlen) > MAX_LEN;
                    r_cnt_d    = 8'd0;
                    rd_en      = 1'b1;
                    rd_addr    = araddr[ADDR_WIDTH+1:2];
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                rvalid    = r_shown_q || !stall_r;
                rlast     = rvalid && (r_cnt_q == r_len_q);
                r_shown_d = rvalid && !rready;
                if (rvalid && rready) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d = r_cnt_q + 8'd1;
                        r_idx_d = r_idx_q + 1'b1;
                        rd_en   = 1'b1;
                        rd_addr = r_idx_q + 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign strb_cnt = 3'(wstrb[0]) + 3'(wstrb[1]) + 3'(wstrb[2]) + 3'(wstrb[3]);
    assign strb_err = ((w_size_q != 3'd2) && (wstrb == 4'hF)) || (int'(strb_cnt) > (1 << w_size_q));

    always_comb begin
        w_state_d   = w_state_q;
        w_idx_d     = w_idx_q;
        w_len_d     = w_len_q;
        w_cnt_d     = w_cnt_q;
        w_size_d    = w_size_q;
        b_shown_d   = 1'b0;
        wr_en       = 1'b0;
        proto_err_d = proto_err_q || ar_len_err;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready = !stall_a;
                if (awvalid && !stall_a) begin
                    w_idx_d   = awaddr[ADDR_WIDTH+1:2];
                    w_len_d   = clamp_len(awlen);
                    w_size_d  = awsize;
                    w_cnt_d   = 8'd0;
                    w_state_d = W_DATA;
                    if (int'(awlen) > MAX_LEN) proto_err_d = 1'b1;
                end
            end
            W_DATA: begin
                wready = !stall_w;
                if (wvalid && !stall_w) begin
                    wr_en   = 1'b1;
                    w_cnt_d = w_cnt_q + 8'd1;
                    w_idx_d = w_idx_q + 1'b1;
                    if ((wlast != (w_cnt_q == w_len_q)) || strb_err) proto_err_d = 1'b1;
                    if (w_cnt_q == w_len_q) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                bvalid    = b_shown_q || !stall_b;
                b_shown_d = bvalid && !bready;
                if (bvalid && bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q   <= R_IDLE;
            r_idx_q     <= '0;
            r_len_q     <= 8'd0;
            r_cnt_q     <= 8'd0;
            r_shown_q   <= 1'b0;
            rdata_q     <= 32'd0;
            w_state_q   <= W_IDLE;
            w_idx_q     <= '0;
            w_len_q     <= 8'd0;
            w_cnt_q     <= 8'd0;
            w_size_q    <= 3'd0;
            b_shown_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            r_idx_q     <= r_idx_d;
            r_len_q     <= r_len_d;
            r_cnt_q     <= r_cnt_d;
            r_shown_q   <= r_shown_d;
            if (rd_en) rdata_q <= mem[rd_addr];
            w_state_q   <= w_state_d;
            w_idx_q     <= w_idx_d;
            w_len_q     <= w_len_d;
            w_cnt_q     <= w_cnt_d;
            w_size_q    <= w_size_d;
            b_shown_q   <= b_shown_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Non-blocking write lands after the same-edge read load, giving read-before-write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (wstrb[k]) mem[w_idx_q][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule
